// File: rtl/ymux_rr_pipe.sv
// CH-input, SIZE-bit valid/ready multiplexer with fixed or round-robin select and one registered output stage.
// Define YMUX_CNT_EN to add the xfer_cnt transfer counter and per-channel starve flags.
module ymux_rr_pipe #(
    parameter int SIZE = 32,
    parameter int CH   = 4,
    parameter int SELW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [CH*SIZE-1:0]   in_data,
    input  logic [CH-1:0]        in_valid,
    output logic [CH-1:0]        in_ready,
    output logic [SIZE-1:0]      out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef YMUX_CNT_EN
    ,
    output logic [15:0]          xfer_cnt,
    output logic [CH-1:0]        starve
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] gnt;
    logic [SELW-1:0] next_ptr;
    logic            grant_exists;
    logic            load_ok;
    logic            xfer;
    logic [SIZE-1:0] gnt_data;
    int              idx;

    assign out_valid = (state == FULL);

    // Reset is folded in so nothing can be accepted while the block is held in reset.
    assign load_ok = rst_n & (~out_valid | out_ready);

    // Fixed mode ignores other channels' valids; round-robin scans backwards so the
    // channel closest to ptr is the last (and therefore winning) assignment.
    always_comb begin
        gnt          = '0;
        grant_exists = 1'b0;
        idx          = 0;
        if (!mode) begin
            if (32'(sel) < CH) begin
                gnt          = sel;
                grant_exists = in_valid[sel];
            end
        end else begin
            for (int i = CH - 1; i >= 0; i--) begin
                idx = 32'(ptr) + i;
                if (idx >= CH) begin
                    idx = idx - CH;
                end
                if (in_valid[idx]) begin
                    gnt          = SELW'(idx);
                    grant_exists = 1'b1;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (load_ok && grant_exists) begin
            in_ready[gnt] = 1'b1;
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int k = 0; k < CH; k++) begin
            if (gnt == SELW'(k)) begin
                gnt_data = in_data[k*SIZE +: SIZE];
            end
        end
    end

    assign xfer     = |(in_valid & in_ready);
    assign next_ptr = (gnt == SELW'(CH - 1)) ? '0 : gnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            out_ch   <= '0;
            ptr      <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (xfer) begin
                        out_data <= gnt_data;
                        out_ch   <= gnt;
                        state    <= FULL;
                    end
                end
                FULL: begin
                    if (xfer) begin
                        out_data <= gnt_data;
                        out_ch   <= gnt;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
            if (xfer && mode) begin
                ptr <= next_ptr;
            end
        end
    end

`ifdef YMUX_CNT_EN
    logic [4:0] wait_cnt [CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (xfer) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end

    // wait_cnt saturates at 16; the flag is sticky until the channel finally transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= '0;
            for (int k = 0; k < CH; k++) begin
                wait_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CH; k++) begin
                if (in_valid[k] && in_ready[k]) begin
                    wait_cnt[k] <= '0;
                    starve[k]   <= 1'b0;
                end else if (in_valid[k]) begin
                    if (wait_cnt[k] != 5'd16) begin
                        wait_cnt[k] <= wait_cnt[k] + 5'd1;
                    end
                    if (wait_cnt[k] == 5'd15) begin
                        starve[k] <= 1'b1;
                    end
                end else begin
                    wait_cnt[k] <= '0;
                end
            end
        end
    end
`endif

endmodule
